// File: rtl/fetch_line_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_line_sequencer
//  Purpose  : Buffers one I-cache line and walks the parser through its
//             4-byte instruction slots from the fetch offset, honouring
//             decoder backpressure; requests the next line at end of line
//             or on a redirect.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_line_sequencer #(
   parameter int offsetSize          = 5,
   parameter int indexSize           = 8,
   parameter int tagSize             = 64 - (offsetSize + indexSize),
   parameter int cachelineSizeInBits = (2**offsetSize) * 8,
   parameter int instrBytes          = 4
) (
   input  logic                           clock_i,
   input  logic                           reset_i,
   input  logic                           flushPipeline_i,
   input  logic                           redirect_i,
   input  logic [63:0]                    redirectAddr_i,
   input  logic                           lineValid_i,
   output logic                           lineReady_o,
   input  logic [cachelineSizeInBits-1:0] cacheline_i,
   input  logic [tagSize-1:0]             lineTag_i,
   input  logic [indexSize-1:0]           lineIndex_i,
   input  logic [offsetSize-1:0]          lineOffset_i,
   input  logic                           stall_i,
   output logic                           parseEnable_o,
   output logic [cachelineSizeInBits-1:0] parseCacheline_o,
   output logic [tagSize-1:0]             parseTag_o,
   output logic [indexSize-1:0]           parseIndex_o,
   output logic [offsetSize-1:0]          parseOffset_o,
   output logic                           nextLineReq_o,
   output logic [63:0]                    nextLineAddr_o,
   output logic                           lineDone_o
);

   localparam int                    LINE_NUM_W    = tagSize + indexSize;
   localparam logic [offsetSize-1:0] INSTR_STEP    = offsetSize'(instrBytes);
   localparam logic [offsetSize-1:0] SLOT_MASK     = offsetSize'(instrBytes - 1);
   localparam logic [offsetSize-1:0] LAST_SLOT     = offsetSize'((2**offsetSize) - instrBytes);
   localparam logic [63:0]           ADDR_OFF_MASK = (64'd1 << offsetSize) - 64'd1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_e;

   state_e                         state_q,          state_d;
   logic                           lineReady_q,      lineReady_d;
   logic                           parseEnable_q,    parseEnable_d;
   logic [cachelineSizeInBits-1:0] parseCacheline_q, parseCacheline_d;
   logic [tagSize-1:0]             parseTag_q,       parseTag_d;
   logic [indexSize-1:0]           parseIndex_q,     parseIndex_d;
   logic [offsetSize-1:0]          parseOffset_q,    parseOffset_d;
   logic                           nextLineReq_q,    nextLineReq_d;
   logic [63:0]                    nextLineAddr_q,   nextLineAddr_d;
   logic                           lineDone_q,       lineDone_d;
   logic [cachelineSizeInBits-1:0] bufLine_q,        bufLine_d;
   logic [tagSize-1:0]             bufTag_q,         bufTag_d;
   logic [indexSize-1:0]           bufIndex_q,       bufIndex_d;
   logic [offsetSize-1:0]          curOffset_q,      curOffset_d;

   // Sequential line number; {tag,index} is treated as one counter so an
   // index carry ripples into the tag and the all-ones case wraps to zero.
   logic [LINE_NUM_W-1:0]          lineNumNext;
   assign lineNumNext = {bufTag_q, bufIndex_q} + LINE_NUM_W'(1);

   // State, buffer and output registers with asynchronous active-low reset.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q          <= IDLE;
         lineReady_q      <= 1'b1;
         parseEnable_q    <= 1'b0;
         parseCacheline_q <= '0;
         parseTag_q       <= '0;
         parseIndex_q     <= '0;
         parseOffset_q    <= '0;
         nextLineReq_q    <= 1'b0;
         nextLineAddr_q   <= '0;
         lineDone_q       <= 1'b0;
         bufLine_q        <= '0;
         bufTag_q         <= '0;
         bufIndex_q       <= '0;
         curOffset_q      <= '0;
      end else begin
         state_q          <= state_d;
         lineReady_q      <= lineReady_d;
         parseEnable_q    <= parseEnable_d;
         parseCacheline_q <= parseCacheline_d;
         parseTag_q       <= parseTag_d;
         parseIndex_q     <= parseIndex_d;
         parseOffset_q    <= parseOffset_d;
         nextLineReq_q    <= nextLineReq_d;
         nextLineAddr_q   <= nextLineAddr_d;
         lineDone_q       <= lineDone_d;
         bufLine_q        <= bufLine_d;
         bufTag_q         <= bufTag_d;
         bufIndex_q       <= bufIndex_d;
         curOffset_q      <= curOffset_d;
      end
   end

   // Next-state and next-output logic; flush beats redirect beats normal flow.
   always_comb begin
      state_d          = state_q;
      lineReady_d      = lineReady_q;
      parseEnable_d    = 1'b0;
      parseCacheline_d = parseCacheline_q;
      parseTag_d       = parseTag_q;
      parseIndex_d     = parseIndex_q;
      parseOffset_d    = parseOffset_q;
      nextLineReq_d    = 1'b0;
      nextLineAddr_d   = nextLineAddr_q;
      lineDone_d       = 1'b0;
      bufLine_d        = bufLine_q;
      bufTag_d         = bufTag_q;
      bufIndex_d       = bufIndex_q;
      curOffset_d      = curOffset_q;

      case (state_q)
         IDLE: begin
            lineReady_d = 1'b1;
            if (lineValid_i) begin
               bufLine_d   = cacheline_i;
               bufTag_d    = lineTag_i;
               bufIndex_d  = lineIndex_i;
               // Misaligned fetch offsets round down to the containing slot.
               curOffset_d = lineOffset_i & ~SLOT_MASK;
               lineReady_d = 1'b0;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            if (!stall_i) begin
               parseEnable_d    = 1'b1;
               parseCacheline_d = bufLine_q;
               parseTag_d       = bufTag_q;
               parseIndex_d     = bufIndex_q;
               parseOffset_d    = curOffset_q;
               curOffset_d      = curOffset_q + INSTR_STEP;
               if (curOffset_q == LAST_SLOT) begin
                  lineDone_d     = 1'b1;
                  nextLineReq_d  = 1'b1;
                  nextLineAddr_d = {lineNumNext, {offsetSize{1'b0}}};
                  lineReady_d    = 1'b1;
                  state_d        = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Redirect drops the buffered line and refetches from the target line.
      if (redirect_i) begin
         state_d        = IDLE;
         lineReady_d    = 1'b1;
         parseEnable_d  = 1'b0;
         lineDone_d     = 1'b0;
         nextLineReq_d  = 1'b1;
         nextLineAddr_d = redirectAddr_i & ~ADDR_OFF_MASK;
         bufLine_d      = '0;
         bufTag_d       = '0;
         bufIndex_d     = '0;
         curOffset_d    = '0;
      end

      // Flush returns everything to the reset picture and suppresses requests.
      if (flushPipeline_i) begin
         state_d          = IDLE;
         lineReady_d      = 1'b1;
         parseEnable_d    = 1'b0;
         parseCacheline_d = '0;
         parseTag_d       = '0;
         parseIndex_d     = '0;
         parseOffset_d    = '0;
         nextLineReq_d    = 1'b0;
         nextLineAddr_d   = '0;
         lineDone_d       = 1'b0;
         bufLine_d        = '0;
         bufTag_d         = '0;
         bufIndex_d       = '0;
         curOffset_d      = '0;
      end
   end

   assign lineReady_o      = lineReady_q;
   assign parseEnable_o    = parseEnable_q;
   assign parseCacheline_o = parseCacheline_q;
   assign parseTag_o       = parseTag_q;
   assign parseIndex_o     = parseIndex_q;
   assign parseOffset_o    = parseOffset_q;
   assign nextLineReq_o    = nextLineReq_q;
   assign nextLineAddr_o   = nextLineAddr_q;
   assign lineDone_o       = lineDone_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_line_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_line_sequencer
//  Purpose  : Scoreboard bench for fetch_line_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_line_sequencer;

   localparam int OFF_W  = 5;
   localparam int IDX_W  = 8;
   localparam int TAG_W  = 64 - (OFF_W + IDX_W);
   localparam int LINE_W = 256;

   logic              clock_i = 1'b0;
   logic              reset_i = 1'b0;
   logic              flushPipeline_i = 1'b0;
   logic              redirect_i = 1'b0;
   logic [63:0]       redirectAddr_i = '0;
   logic              lineValid_i = 1'b0;
   logic              lineReady_o;
   logic [LINE_W-1:0] cacheline_i = '0;
   logic [TAG_W-1:0]  lineTag_i = '0;
   logic [IDX_W-1:0]  lineIndex_i = '0;
   logic [OFF_W-1:0]  lineOffset_i = '0;
   logic              stall_i = 1'b0;
   logic              parseEnable_o;
   logic [LINE_W-1:0] parseCacheline_o;
   logic [TAG_W-1:0]  parseTag_o;
   logic [IDX_W-1:0]  parseIndex_o;
   logic [OFF_W-1:0]  parseOffset_o;
   logic              nextLineReq_o;
   logic [63:0]       nextLineAddr_o;
   logic              lineDone_o;

   fetch_line_sequencer dut (
      .clock_i          (clock_i),
      .reset_i          (reset_i),
      .flushPipeline_i  (flushPipeline_i),
      .redirect_i       (redirect_i),
      .redirectAddr_i   (redirectAddr_i),
      .lineValid_i      (lineValid_i),
      .lineReady_o      (lineReady_o),
      .cacheline_i      (cacheline_i),
      .lineTag_i        (lineTag_i),
      .lineIndex_i      (lineIndex_i),
      .lineOffset_i     (lineOffset_i),
      .stall_i          (stall_i),
      .parseEnable_o    (parseEnable_o),
      .parseCacheline_o (parseCacheline_o),
      .parseTag_o       (parseTag_o),
      .parseIndex_o     (parseIndex_o),
      .parseOffset_o    (parseOffset_o),
      .nextLineReq_o    (nextLineReq_o),
      .nextLineAddr_o   (nextLineAddr_o),
      .lineDone_o       (lineDone_o)
   );

   always #5 clock_i = ~clock_i;

   typedef struct {
      logic [OFF_W-1:0]  off;
      logic [TAG_W-1:0]  tag;
      logic [IDX_W-1:0]  idx;
      logic [LINE_W-1:0] line;
      logic              last;
   } iss_t;

   iss_t        issQ[$];
   logic [63:0] reqQ[$];
   iss_t        mon_e;
   logic [63:0] mon_a;
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   // Expected slot issues from the rounded start offset up to stop_off.
   function automatic void push_line(input logic [TAG_W-1:0] tag, input logic [IDX_W-1:0] idx,
                                     input logic [OFF_W-1:0] off, input logic [LINE_W-1:0] line,
                                     input int stop_off, input bit with_req);
      iss_t e;
      for (int o = int'(off) & ~3; o <= stop_off; o += 4) begin
         e.off  = o[OFF_W-1:0];
         e.tag  = tag;
         e.idx  = idx;
         e.line = line;
         e.last = (o == 28);
         issQ.push_back(e);
      end
      if (with_req) reqQ.push_back({tag, idx, 5'b0} + 64'h20);
   endfunction

   // Present a line for one capture edge.
   task automatic send_line(input logic [TAG_W-1:0] tag, input logic [IDX_W-1:0] idx,
                            input logic [OFF_W-1:0] off, input logic [LINE_W-1:0] line,
                            input int stop_off, input bit with_req);
      cacheline_i  = line;
      lineTag_i    = tag;
      lineIndex_i  = idx;
      lineOffset_i = off;
      lineValid_i  = 1'b1;
      push_line(tag, idx, off, line, stop_off, with_req);
      tick();
      lineValid_i  = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && (issQ.size() != 0 || reqQ.size() != 0); i++) tick();
      chk("drain_issues", 256'(issQ.size()), 256'd0);
      chk("drain_reqs", 256'(reqQ.size()), 256'd0);
   endtask

   function automatic logic [LINE_W-1:0] rnd_line();
      logic [LINE_W-1:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom();
      return l;
   endfunction

   // Output monitor: every issued slot and every request pulse is popped
   // from the scoreboard and compared.
   always @(negedge clock_i) begin
      if (reset_i) begin
         if (parseEnable_o) begin
            if (issQ.size() == 0) begin
               chk("unexpected_issue", {251'd0, parseOffset_o}, 256'h1_0000);
            end else begin
               mon_e = issQ.pop_front();
               chk("offset", 256'(parseOffset_o), 256'(mon_e.off));
               chk("tag", 256'(parseTag_o), 256'(mon_e.tag));
               chk("index", 256'(parseIndex_o), 256'(mon_e.idx));
               chk("line", parseCacheline_o, mon_e.line);
               chk("lineDone", 256'(lineDone_o), 256'(mon_e.last));
            end
         end else if (lineDone_o) begin
            chk("stray_lineDone", 256'(lineDone_o), 256'd0);
         end
         if (nextLineReq_o) begin
            if (reqQ.size() == 0) begin
               chk("unexpected_req", 256'(nextLineAddr_o), 256'h1_0000_0000_0000_0000);
            end else begin
               mon_a = reqQ.pop_front();
               chk("nextLineAddr", 256'(nextLineAddr_o), 256'(mon_a));
            end
         end
      end
   end

   initial begin
      logic [LINE_W-1:0] la;
      logic [LINE_W-1:0] lb;

      // Reset values.
      tick();
      tick();
      chk("rst_ready", 256'(lineReady_o), 256'd1);
      chk("rst_pe", 256'(parseEnable_o), 256'd0);
      chk("rst_req", 256'(nextLineReq_o), 256'd0);
      chk("rst_done", 256'(lineDone_o), 256'd0);
      chk("rst_addr", 256'(nextLineAddr_o), 256'd0);
      chk("rst_offset", 256'(parseOffset_o), 256'd0);
      reset_i = 1'b1;
      tick();

      // Full line from offset 0.
      send_line(51'h5, 8'h10, 5'd0, rnd_line(), 28, 1'b1);
      drain();

      // Misaligned start offset 21 -> slots 20, 24, 28.
      send_line(51'h1234, 8'h3c, 5'd21, rnd_line(), 28, 1'b1);
      drain();
      chk("ready_after_line", 256'(lineReady_o), 256'd1);

      // Stall for three cycles after the slot at offset 8.
      send_line(51'h77, 8'h01, 5'd0, rnd_line(), 28, 1'b1);
      tick();
      tick();
      tick();
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_pe", 256'(parseEnable_o), 256'd0);
         chk("stall_offset", 256'(parseOffset_o), 256'd8);
      end
      stall_i = 1'b0;
      tick();
      chk("resume_offset", 256'(parseOffset_o), 256'd12);
      drain();

      // Index carry into tag, and full wrap to zero.
      send_line(51'h3, 8'hff, 5'd28, rnd_line(), 28, 1'b1);
      drain();
      send_line({TAG_W{1'b1}}, 8'hff, 5'd30, rnd_line(), 28, 1'b1);
      drain();
      chk("wrap_addr", 256'(nextLineAddr_o), 256'd0);

      // Line offered during ISSUE is held by the cache and taken after a bubble.
      la = rnd_line();
      lb = rnd_line();
      send_line(51'h9, 8'h40, 5'd24, la, 28, 1'b1);
      cacheline_i  = lb;
      lineTag_i    = 51'ha;
      lineIndex_i  = 8'h41;
      lineOffset_i = 5'd28;
      lineValid_i  = 1'b1;
      push_line(51'ha, 8'h41, 5'd28, lb, 28, 1'b1);
      tick();
      tick();
      tick();
      lineValid_i = 1'b0;
      drain();

      // Redirect at the slot at offset 12.
      send_line(51'h21, 8'h22, 5'd0, rnd_line(), 12, 1'b0);
      reqQ.push_back(64'h1220);
      tick();
      tick();
      tick();
      tick();
      redirect_i     = 1'b1;
      redirectAddr_i = 64'h1234;
      tick();
      redirect_i = 1'b0;
      chk("redir_req", 256'(nextLineReq_o), 256'd1);
      chk("redir_addr", 256'(nextLineAddr_o), 256'h1220);
      chk("redir_pe", 256'(parseEnable_o), 256'd0);
      chk("redir_ready", 256'(lineReady_o), 256'd1);
      tick();
      chk("redir_pulse_end", 256'(nextLineReq_o), 256'd0);
      chk("redir_idle_pe", 256'(parseEnable_o), 256'd0);
      drain();

      // Flush together with redirect: no request, everything back to reset.
      send_line(51'h31, 8'h32, 5'd0, rnd_line(), 12, 1'b0);
      tick();
      tick();
      tick();
      tick();
      redirect_i      = 1'b1;
      redirectAddr_i  = 64'habcd;
      flushPipeline_i = 1'b1;
      tick();
      redirect_i      = 1'b0;
      flushPipeline_i = 1'b0;
      chk("flush_req", 256'(nextLineReq_o), 256'd0);
      chk("flush_addr", 256'(nextLineAddr_o), 256'd0);
      chk("flush_pe", 256'(parseEnable_o), 256'd0);
      chk("flush_offset", 256'(parseOffset_o), 256'd0);
      chk("flush_tag", 256'(parseTag_o), 256'd0);
      chk("flush_index", 256'(parseIndex_o), 256'd0);
      chk("flush_line", parseCacheline_o, 256'd0);
      chk("flush_ready", 256'(lineReady_o), 256'd1);
      tick();
      drain();

      // Asynchronous reset mid-line, between clock edges.
      send_line(51'h7, 8'h22, 5'd0, rnd_line(), 8, 1'b0);
      tick();
      tick();
      tick();
      #5;
      reset_i = 1'b0;
      #1;
      chk("arst_pe", 256'(parseEnable_o), 256'd0);
      chk("arst_ready", 256'(lineReady_o), 256'd1);
      chk("arst_offset", 256'(parseOffset_o), 256'd0);
      chk("arst_line", parseCacheline_o, 256'd0);
      tick();
      tick();
      reset_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("arst_no_req", 256'(nextLineReq_o), 256'd0);
         chk("arst_no_done", 256'(lineDone_o), 256'd0);
      end
      chk("arst_issues_left", 256'(issQ.size()), 256'd0);
      chk("arst_reqs_left", 256'(reqQ.size()), 256'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
